// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and duty scaling for the multi-channel PWM generator
package pwm_pkg;
  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  // Keep the upper cnt_w bits of a duty_w-wide duty, or zero-extend a narrower one
  function automatic logic [31:0] scale_duty(input logic [31:0] d, input int duty_w, input int cnt_w);
    return (duty_w >= cnt_w) ? d >> (duty_w - cnt_w) : d;
  endfunction
endpackage

// File: rtl/pwm_kanal.sv
// pwm_kanal: one PWM channel with staged/shadowed duty, compare and output register
module pwm_kanal
  import pwm_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int DUTY_W = 15,
  parameter bit INVERT = 1'b1
) (
  input  logic              clk1,
  input  logic              arst_n,
  input  logic              en,
  input  logic              duty_wr,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty,
  input  logic [CNT_W-1:0]  cnt,
  output logic              pwm_iz
);
  logic [CNT_W-1:0] stg_q, stg_d, sh_q, sh_d;
  logic             raw_q, raw_d;
  always_comb begin
    stg_d = duty_wr ? CNT_W'(scale_duty(32'(duty), DUTY_W, CNT_W)) : stg_q;
    sh_d  = load ? stg_q : sh_q;
    raw_d = en & (cnt < sh_q);
  end
  always_ff @(posedge clk1 or negedge arst_n) begin
    if (!arst_n) begin
      stg_q <= '0;
      sh_q  <= '0;
      raw_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      sh_q  <= sh_d;
      raw_q <= raw_d;
    end
  end
  assign pwm_iz = raw_q ^ INVERT;
endmodule

// File: rtl/pwm_visekanalni.sv
// pwm_visekanalni: N-channel PWM with one shared edge/centre-aligned counter and
// double-buffered period, mode and duty that change only at a period boundary
module pwm_visekanalni
  import pwm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 12,
  parameter int DUTY_W = 15,
  parameter bit INVERT = 1'b1
) (
  input  logic                   clk1,
  input  logic                   arst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [CNT_W-1:0]       period,
  input  logic [N_CH*DUTY_W-1:0] duty,
  input  logic                   duty_wr,
  output logic                   upd_pending,
  output logic                   period_start,
  output logic [N_CH-1:0]        pwm_iz
);
  localparam logic [0:0]       ST_UP   = 1'b0;
  localparam logic [0:0]       ST_DOWN = 1'b1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d, stg_p_q, stg_p_d, sh_p_q, sh_p_d, p_nx;
  pwm_mode_e        stg_m_q, stg_m_d, sh_m_q, sh_m_d;
  logic [0:0]       dir_q, dir_d;
  logic             pend_q, pend_d, ps_q, ps_d, boundary, load;
  always_comb begin
    boundary = (cnt_q == '0) && (dir_q == ST_UP);
    load     = ~en | (boundary & pend_q & ~duty_wr);
    stg_p_d  = duty_wr ? period : stg_p_q;
    stg_m_d  = duty_wr ? pwm_mode_e'(mode) : stg_m_q;
    sh_p_d   = load ? stg_p_q : sh_p_q;
    sh_m_d   = load ? stg_m_q : sh_m_q;
    pend_d   = duty_wr | (pend_q & ~load);
    ps_d     = en & boundary;
    // A period transferring in this boundary already governs the step out of cnt=0
    p_nx     = (boundary && load) ? stg_p_q : sh_p_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = ST_UP;
    end else if (dir_q == ST_DOWN) begin
      cnt_d = cnt_q - ONE;
      dir_d = (cnt_q == ONE) ? ST_UP : ST_DOWN;
    end else if (cnt_q < p_nx) begin
      cnt_d = cnt_q + ONE;
    end else if (sh_m_q == PWM_EDGE || p_nx == '0) begin
      cnt_d = '0;
    end else begin
      cnt_d = p_nx - ONE;
      dir_d = (p_nx == ONE) ? ST_UP : ST_DOWN;
    end
  end
  always_ff @(posedge clk1 or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q   <= '0;
      dir_q   <= ST_UP;
      stg_p_q <= '0;
      sh_p_q  <= '0;
      stg_m_q <= PWM_EDGE;
      sh_m_q  <= PWM_EDGE;
      pend_q  <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      stg_p_q <= stg_p_d;
      sh_p_q  <= sh_p_d;
      stg_m_q <= stg_m_d;
      sh_m_q  <= sh_m_d;
      pend_q  <= pend_d;
      ps_q    <= ps_d;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_kanal #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .INVERT(INVERT)) u_kanal (
      .clk1    (clk1),
      .arst_n  (arst_n),
      .en      (en),
      .duty_wr (duty_wr),
      .load    (load),
      .duty    (duty[k*DUTY_W +: DUTY_W]),
      .cnt     (cnt_q),
      .pwm_iz  (pwm_iz[k])
    );
  end
  assign upd_pending  = pend_q;
  assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_visekanalni.sv
// tb_pwm_visekanalni: directed checks of the 2-channel, 4-bit, inverting PWM configuration
module tb_pwm_visekanalni;
  localparam int N_CH = 2, CNT_W = 4, DUTY_W = 7;
  logic                   clk1 = 1'b0, arst_n = 1'b0, en = 1'b0, mode = 1'b0, duty_wr = 1'b0;
  logic [CNT_W-1:0]       period = '0;
  logic [N_CH*DUTY_W-1:0] duty = '0;
  logic                   upd_pending, period_start;
  logic [N_CH-1:0]        pwm_iz;
  logic [1:0]             pw_r [0:39];
  logic                   ps_r [0:39];
  logic                   pd_r [0:39];
  logic [7:0]             pat;
  int n_tests = 0, n_fail = 0;

  pwm_visekanalni #(.N_CH(N_CH), .CNT_W(CNT_W), .DUTY_W(DUTY_W), .INVERT(1'b1)) dut (
    .clk1         (clk1),
    .arst_n       (arst_n),
    .en           (en),
    .mode         (mode),
    .period       (period),
    .duty         (duty),
    .duty_wr      (duty_wr),
    .upd_pending  (upd_pending),
    .period_start (period_start),
    .pwm_iz       (pwm_iz)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic rec(input int s);
    tick();
    pw_r[s] = pwm_iz;
    ps_r[s] = period_start;
    pd_r[s] = upd_pending;
  endtask

  // Disabled write: the shadow is transparent, so values are live once en rises
  task automatic load_dis(input int d0, input int d1, input int p, input logic m);
    en      = 1'b0;
    duty    = {7'(d1), 7'(d0)};
    period  = 4'(p);
    mode    = m;
    duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    tick();
  endtask

  function automatic int lows(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += (pw_r[i][0] == 1'b0) ? 1 : 0;
    return c;
  endfunction

  function automatic int ones1(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += (pw_r[i][1] == 1'b1) ? 1 : 0;
    return c;
  endfunction

  function automatic int pscnt(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += (ps_r[i] == 1'b1) ? 1 : 0;
    return c;
  endfunction

  initial begin
    #3;
    chk("rst_pwm", pwm_iz, 3);
    chk("rst_ps", period_start, 0);
    chk("rst_pend", upd_pending, 0);
    tick();
    arst_n = 1'b1;
    tick();
    load_dis(40, 0, 9, 1'b0);
    chk("dis_pwm", pwm_iz, 3);
    chk("dis_ps", period_start, 0);
    en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if (s == 23) begin
        duty[6:0] = 7'd16;
        duty_wr   = 1'b1;
      end
      rec(s);
      if (s == 23) begin
        duty_wr = 1'b0;
        chk("pend_set", upd_pending, 1);
      end
    end
    chk("edge_low_a", lows(0, 9), 5);
    chk("edge_low_b", lows(10, 19), 5);
    chk("ch1_high", ones1(0, 39), 40);
    chk("edge_ps_cnt", pscnt(0, 19), 2);
    chk("edge_ps_first", ps_r[0], 1);
    chk("edge_ps_10", ps_r[10], 1);
    chk("shadow_old", lows(20, 29), 5);
    chk("shadow_new", lows(30, 39), 2);
    chk("pend_before", pd_r[29], 1);
    chk("pend_after", pd_r[30], 0);

    load_dis(16, 0, 4, 1'b1);
    en = 1'b1;
    for (int s = 0; s < 16; s++) rec(s);
    for (int i = 0; i < 8; i++) pat[i] = pw_r[i][0];
    chk("ctr_pattern", pat, 8'h7C);
    chk("ctr_low", lows(8, 15), 3);
    chk("ctr_ps_cnt", pscnt(0, 15), 2);
    chk("ctr_ps_8", ps_r[8], 1);

    load_dis(127, 0, 9, 1'b0);
    en = 1'b1;
    for (int s = 0; s < 10; s++) rec(s);
    chk("full_duty", lows(0, 9), 10);
    load_dis(127, 0, 0, 1'b0);
    en = 1'b1;
    for (int s = 0; s < 5; s++) rec(s);
    chk("p0_ps", pscnt(0, 4), 5);
    chk("p0_pwm", lows(0, 4), 5);

    load_dis(40, 0, 9, 1'b0);
    en = 1'b1;
    for (int s = 0; s < 32; s++) begin
      if (s == 10 || s == 31) begin
        duty[6:0] = 7'd16;
        duty_wr   = 1'b1;
      end
      rec(s);
      duty_wr = 1'b0;
    end
    chk("bnd_wr_pend", pd_r[10], 1);
    chk("bnd_wr_pend_19", pd_r[19], 1);
    chk("bnd_wr_pend_20", pd_r[20], 0);
    chk("bnd_wr_old", lows(10, 19), 5);
    chk("bnd_wr_new", lows(20, 29), 2);
    chk("pre_rst_pend", pd_r[31], 1);
    chk("pre_rst_pwm", pw_r[31][0], 0);

    arst_n = 1'b0;
    #1;
    chk("midrst_pwm", pwm_iz, 3);
    chk("midrst_ps", period_start, 0);
    chk("midrst_pend", upd_pending, 0);
    tick();
    arst_n = 1'b1;
    tick();
    chk("restart_ps", period_start, 1);
    chk("restart_pwm", pwm_iz, 3);
    chk("restart_pend", upd_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
